clk_en_gen: RTL and testbench

- Parametrised successor to the free-running clock divider.
- Generates NCH independent, runtime-programmable clock-enable channels from the single master clock.
- Each channel emits a one-cycle tick strobe and a near-50% square wave.
- Display, audio and scan logic consume the ticks as clock enables instead of using derived clocks.
- Adds per-channel run/hold, glitch-free divisor reprogramming and a global phase-aligned restart.

---
 rtl/clk_en_pkg.sv | 14 +
 rtl/clk_en_chan.sv | 63 ++++++
 rtl/clk_en_gen.sv | 38 +++
 tb/tb_clk_en_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared constants and divisor helpers for the clock-enable generator
package clk_en_pkg;
    localparam int DEF_CNT_W   = 25;
    localparam int DEF_DIV_VAL = 4;
    localparam int FN_W        = 32;

    function automatic logic [FN_W-1:0] clamp_div(input logic [FN_W-1:0] d);
        return (d == '0) ? FN_W'(1) : d;
    endfunction

    function automatic logic [FN_W-1:0] half_hi(input logic [FN_W-1:0] d);
        return FN_W'((33'(d) + 33'd1) >> 1);
    endfunction
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one clock-enable channel with tick strobe, square wave and shadowed divisor
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] div,
    output logic             tick,
    output logic             sq
);
    logic [CNT_W-1:0] cnt, shadow, wval, nxt;
    logic             pending, last;

    // >= so a held count left above a smaller divisor still wraps on the next edge
    always_comb begin
        wval = CNT_W'(clamp_div(FN_W'(wdata)));
        last = cnt >= div - CNT_W'(1);
        nxt  = last ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt     <= '0;
            div     <= CNT_W'(DEF_DIV);
            shadow  <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else if (restart) begin
            cnt     <= '0;
            tick    <= 1'b0;
            sq      <= en;
            div     <= wr ? wval : pending ? shadow : div;
            pending <= 1'b0;
        end else begin
            if (wr)
                shadow <= wval;
            if (wr && !en) begin
                div     <= wval;
                pending <= 1'b0;
            end else if (pending && (!en || last)) begin
                div     <= shadow;
                pending <= wr;
            end else begin
                pending <= pending | wr;
            end
            if (en) begin
                cnt  <= nxt;
                tick <= last;
                sq   <= nxt < CNT_W'(half_hi(FN_W'(div)));
            end else begin
                tick <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: NCH programmable clock-enable channels with write decode and divisor readback
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_VAL,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [NCH-1:0]   en,
    input  logic             restart,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [CNT_W-1:0] rd_div,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq
);
    logic [CNT_W-1:0] divs [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_en_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
            .clk     (clk),
            .clr_n   (clr_n),
            .en      (en[g]),
            .restart (restart),
            .wr      (cfg_we && (cfg_ch == CH_W'(g))),
            .wdata   (cfg_div),
            .div     (divs[g]),
            .tick    (tick[g]),
            .sq      (sq[g])
        );
    end

    assign rd_div = (32'(cfg_ch) < NCH) ? divs[cfg_ch] : '0;
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed checks of tick/sq timing, reprogramming, restart and reset
module tb_clk_en_gen;
    localparam int W = 25;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic [3:0]   en = '0;
    logic         restart = 1'b0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic [W-1:0] rd_div;
    logic [3:0]   tick, sq;

    logic [2:0]   en3 = '0;
    logic         we3 = 1'b0;
    logic [1:0]   ch3 = '0;
    logic [W-1:0] rd_div3;
    logic [2:0]   tick3, sq3;

    int checks = 0;
    int errors = 0;

    clk_en_gen #(.NCH(4)) dut (
        .clk(clk), .clr_n(clr_n), .en(en), .restart(restart), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .rd_div(rd_div), .tick(tick), .sq(sq)
    );

    clk_en_gen #(.NCH(3)) dut3 (
        .clk(clk), .clr_n(clr_n), .en(en3), .restart(restart), .cfg_we(we3),
        .cfg_ch(ch3), .cfg_div(cfg_div), .rd_div(rd_div3), .tick(tick3), .sq(sq3)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        en = 4'b0001;
        cyc();
        cyc();
        checks++;
        if (tick !== 4'b0 || sq !== 4'b0) begin
            errors++;
            $display("FAIL reset_out tick=%b sq=%b want 0000/0000", tick, sq);
        end
        checks++;
        if (rd_div !== W'(4)) begin
            errors++;
            $display("FAIL reset_rd_div got %0d want 4", rd_div);
        end
        clr_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            checks++;
            if (tick !== {3'b0, (k % 4) == 0} || sq !== {3'b0, (k % 4) < 2}) begin
                errors++;
                $display("FAIL div4_run k=%0d tick=%b sq=%b want %b/%b", k, tick, sq,
                         {3'b0, (k % 4) == 0}, {3'b0, (k % 4) < 2});
            end
        end
    endtask

    task automatic test_reprogram();
        cyc();
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = W'(7);
        cyc();
        cfg_we = 1'b0;
        checks++;
        if (rd_div !== W'(4) || tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL reprog_cnt2 rd_div=%0d tick0=%b want 4/0", rd_div, tick[0]);
        end
        cyc();
        checks++;
        if (rd_div !== W'(4) || sq[0] !== 1'b0) begin
            errors++;
            $display("FAIL reprog_cnt3 rd_div=%0d sq0=%b want 4/0", rd_div, sq[0]);
        end
        cyc();
        checks++;
        if (rd_div !== W'(7) || tick[0] !== 1'b1 || sq[0] !== 1'b1) begin
            errors++;
            $display("FAIL reprog_apply rd_div=%0d tick0=%b sq0=%b want 7/1/1", rd_div, tick[0], sq[0]);
        end
        for (int k = 1; k <= 7; k++) begin
            cyc();
            checks++;
            if (tick[0] !== ((k % 7) == 0) || sq[0] !== ((k % 7) < 4)) begin
                errors++;
                $display("FAIL div7_run k=%0d tick0=%b sq0=%b want %b/%b", k, tick[0], sq[0],
                         (k % 7) == 0, (k % 7) < 4);
            end
        end
    endtask

    task automatic test_div_zero();
        cfg_we = 1'b1;
        cfg_ch = 2'd1;
        cfg_div = '0;
        cyc();
        cfg_we = 1'b0;
        checks++;
        if (rd_div !== W'(1)) begin
            errors++;
            $display("FAIL clamp_rd_div got %0d want 1", rd_div);
        end
        en = 4'b0011;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++;
            if (tick[1] !== 1'b1 || sq[1] !== 1'b1) begin
                errors++;
                $display("FAIL div1_run k=%0d tick1=%b sq1=%b want 1/1", k, tick[1], sq[1]);
            end
        end
    endtask

    task automatic test_restart();
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = W'(5);
        cyc();
        cfg_ch = 2'd2;
        cfg_div = W'(3);
        cyc();
        cfg_we = 1'b0;
        en = 4'b0101;
        cyc();
        cyc();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        cfg_ch = 2'd0;
        #1;
        checks++;
        if (tick !== 4'b0 || sq !== 4'b0101) begin
            errors++;
            $display("FAIL restart_out tick=%b sq=%b want 0000/0101", tick, sq);
        end
        checks++;
        if (rd_div !== W'(5)) begin
            errors++;
            $display("FAIL restart_rd_div got %0d want 5", rd_div);
        end
        for (int k = 1; k <= 15; k++) begin
            cyc();
            checks++;
            if (tick[0] !== ((k % 5) == 0) || tick[2] !== ((k % 3) == 0) ||
                sq[0] !== ((k % 5) < 3) || sq[2] !== ((k % 3) < 2)) begin
                errors++;
                $display("FAIL aligned_run k=%0d tick=%b sq=%b", k, tick, sq);
            end
        end
    endtask

    task automatic test_hold();
        en = 4'b0000;
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = W'(4);
        cyc();
        cfg_we = 1'b0;
        en = 4'b0001;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        cyc();
        cyc();
        checks++;
        if (sq[0] !== 1'b0 || tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_pre sq0=%b tick0=%b want 0/0", sq[0], tick[0]);
        end
        en = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if (tick[0] !== 1'b0 || sq[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold k=%0d tick0=%b sq0=%b want 0/0", k, tick[0], sq[0]);
            end
        end
        en = 4'b0001;
        cyc();
        checks++;
        if (tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL resume1 tick0=%b want 0", tick[0]);
        end
        cyc();
        checks++;
        if (tick[0] !== 1'b1 || sq[0] !== 1'b1) begin
            errors++;
            $display("FAIL resume2 tick0=%b sq0=%b want 1/1", tick[0], sq[0]);
        end
    endtask

    task automatic test_reset_pending();
        en = 4'b1000;
        cfg_we = 1'b1;
        cfg_ch = 2'd3;
        cfg_div = W'(9);
        cyc();
        cfg_we = 1'b0;
        clr_n = 1'b0;
        cyc();
        clr_n = 1'b1;
        checks++;
        if (tick !== 4'b0 || sq !== 4'b0 || rd_div !== W'(4)) begin
            errors++;
            $display("FAIL midreset tick=%b sq=%b rd_div=%0d want 0000/0000/4", tick, sq, rd_div);
        end
        for (int k = 1; k <= 4; k++)
            cyc();
        checks++;
        if (tick[3] !== 1'b1 || rd_div !== W'(4)) begin
            errors++;
            $display("FAIL discard tick3=%b rd_div=%0d want 1/4", tick[3], rd_div);
        end
    endtask

    task automatic test_bad_channel();
        we3 = 1'b1;
        ch3 = 2'd3;
        cfg_div = W'(9);
        cyc();
        we3 = 1'b0;
        checks++;
        if (rd_div3 !== '0) begin
            errors++;
            $display("FAIL bad_ch_rd got %0d want 0", rd_div3);
        end
        for (int c = 0; c < 3; c++) begin
            ch3 = 2'(c);
            #1;
            checks++;
            if (rd_div3 !== W'(4)) begin
                errors++;
                $display("FAIL bad_ch_alias ch=%0d got %0d want 4", c, rd_div3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reprogram();
        test_div_zero();
        test_restart();
        test_hold();
        test_reset_pending();
        test_bad_channel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
